ip_line_stack: RTL and testbench

Instruction-pointer sequencer with a hardware loop-return stack and a bracket-scan fallback, sitting between the ROM and the instruction decoder of the DekatronPC core. On each request it advances the BCD instruction pointer, fetches the next instruction from ROM and presents it on `Insn`. Backward jumps on `]` with non-zero data resolve in one fetch from the stack. Forward skips, and backward jumps whose `[` was not stacked, use a nesting-depth scan. IP width, scan depth and stack depth are parametrised.

---
 rtl/dpc_pkg.sv | 23 ++
 rtl/bcd_incdec.sv | 43 ++++
 rtl/ip_line_stack.sv | 235 +++++++++++++++++++++++
 tb/tb_ip_line_stack.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpc_pkg.sv
// rtl/dpc_pkg.sv - shared DekatronPC instruction encodings and sequencer enums
package dpc_pkg;

   localparam int INSN_WIDTH = 4;

   localparam logic [INSN_WIDTH-1:0] INSN_NOP        = 4'h0;
   localparam logic [INSN_WIDTH-1:0] INSN_LOOP_OPEN  = 4'h6;
   localparam logic [INSN_WIDTH-1:0] INSN_LOOP_CLOSE = 4'h7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROM_WAIT,
      S_DONE,
      S_HALT
   } state_t;

   typedef enum logic [1:0] {
      M_NORMAL,
      M_FWD,
      M_BWD
   } mode_t;

endpackage

// File: rtl/bcd_incdec.sv
// rtl/bcd_incdec.sv - combinational N-digit BCD +/-1 with wrap flag
module bcd_incdec #(
   parameter int DIGITS = 4
) (
   input  logic [DIGITS*4-1:0] value,
   input  logic                dec,
   output logic [DIGITS*4-1:0] result,
   output logic                wrap
);

   logic       carry;
   logic [3:0] digit;

   // Ripple borrow/carry: a digit only moves while every lower digit rolled over.
   always_comb begin
      carry  = 1'b1;
      digit  = 4'd0;
      result = value;
      for (int i = 0; i < DIGITS; i++) begin
         digit = value[i*4 +: 4];
         if (carry) begin
            if (dec) begin
               if (digit == 4'd0) begin
                  digit = 4'd9;
               end else begin
                  digit = digit - 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (digit == 4'd9) begin
                  digit = 4'd0;
               end else begin
                  digit = digit + 4'd1;
                  carry = 1'b0;
               end
            end
         end
         result[i*4 +: 4] = digit;
      end
      wrap = carry;
   end

endmodule

// File: rtl/ip_line_stack.sv
// rtl/ip_line_stack.sv - BCD instruction-pointer sequencer with loop-return stack and bracket scan
module ip_line_stack
   import dpc_pkg::*;
#(
   parameter int IP_DIGITS   = 4,
   parameter int STACK_DEPTH = 8,
   parameter int SCAN_WIDTH  = 8,
   parameter int MISS_WIDTH  = 8
) (
   input  logic                               Clk,
   input  logic                               Rst_n,
   input  logic                               HaltRq,
   input  logic                               DataIsZero,
   input  logic                               Request,
   output logic                               Ready,
   output logic [IP_DIGITS*4-1:0]             IpAddress,
   output logic [SCAN_WIDTH-1:0]              LoopDepth,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   StackLevel,
   output logic                               StackOverflow,
   output logic                               Fault,
   output logic                               RomRequest,
   input  logic                               RomReady,
   input  logic [INSN_WIDTH-1:0]              RomData,
   output logic [INSN_WIDTH-1:0]              Insn
);

   localparam int IPW = IP_DIGITS * 4;
   localparam int LW  = $clog2(STACK_DEPTH + 1);
   localparam logic [SCAN_WIDTH-1:0] DEPTH_ONE = SCAN_WIDTH'(1);

   state_t                  state, state_n;
   mode_t                   mode, mode_n;
   logic                    primed, primed_n;
   logic [IPW-1:0]          ip, ip_n;
   logic [INSN_WIDTH-1:0]   insn, insn_n;
   logic [LW-1:0]           level;
   logic [MISS_WIDTH-1:0]   miss, miss_n;
   logic [SCAN_WIDTH-1:0]   depth, depth_n;
   logic                    ovf, ovf_n;
   logic                    fault, fault_n;
   logic                    rom_req, rom_req_n;
   logic                    push, pop, raise_fault;
   logic [IPW-1:0]          ip_inc, ip_dec;
   logic                    inc_wrap, dec_wrap;
   logic                    full, empty;
   logic [LW-1:0]           top_idx;
   logic [IPW-1:0]          top_ip;

   // Sized to the pointer range so any level value indexes cleanly; only STACK_DEPTH entries are used.
   logic [IPW-1:0]          stack [0:(1<<LW)-1];

   bcd_incdec #(.DIGITS(IP_DIGITS)) u_ip_inc (
      .value  (ip),
      .dec    (1'b0),
      .result (ip_inc),
      .wrap   (inc_wrap)
   );

   bcd_incdec #(.DIGITS(IP_DIGITS)) u_ip_dec (
      .value  (ip),
      .dec    (1'b1),
      .result (ip_dec),
      .wrap   (dec_wrap)
   );

   assign full    = (level == LW'(STACK_DEPTH));
   assign empty   = (level == '0);
   assign top_idx = level - 1'b1;
   assign top_ip  = stack[top_idx];

   always_comb begin
      state_n     = state;
      mode_n      = mode;
      primed_n    = primed;
      ip_n        = ip;
      insn_n      = insn;
      miss_n      = miss;
      depth_n     = depth;
      ovf_n       = ovf;
      fault_n     = fault;
      rom_req_n   = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      raise_fault = 1'b0;
      case (state)
         S_IDLE: begin
            if (HaltRq) begin
               state_n = S_HALT;
            end else if (Request) begin
               state_n   = S_ROM_WAIT;
               rom_req_n = 1'b1;
               if (!primed) begin
                  primed_n = 1'b1;
               end else if (insn == INSN_LOOP_OPEN && !DataIsZero) begin
                  ip_n = ip_inc;
                  if (!full) begin
                     push = 1'b1;
                  end else if (&miss) begin
                     raise_fault = 1'b1;
                  end else begin
                     miss_n = miss + 1'b1;
                     ovf_n  = 1'b1;
                  end
               end else if (insn == INSN_LOOP_OPEN) begin
                  depth_n     = DEPTH_ONE;
                  mode_n      = M_FWD;
                  ip_n        = ip_inc;
                  raise_fault = inc_wrap;
               end else if (insn == INSN_LOOP_CLOSE && !DataIsZero) begin
                  if (miss == '0 && !empty) begin
                     ip_n = top_ip;
                     pop  = 1'b1;
                  end else begin
                     // The matching '[' was never stacked: find it by scanning back.
                     if (miss != '0) miss_n = miss - 1'b1;
                     depth_n     = DEPTH_ONE;
                     mode_n      = M_BWD;
                     ip_n        = ip_dec;
                     raise_fault = dec_wrap;
                  end
               end else if (insn == INSN_LOOP_CLOSE) begin
                  ip_n = ip_inc;
                  if (miss != '0) begin
                     miss_n = miss - 1'b1;
                  end else if (!empty) begin
                     pop = 1'b1;
                  end
               end else begin
                  ip_n = ip_inc;
               end
            end
         end
         S_ROM_WAIT: begin
            if (RomReady) begin
               case (mode)
                  M_FWD: begin
                     ip_n      = ip_inc;
                     rom_req_n = 1'b1;
                     if (RomData == INSN_LOOP_OPEN) begin
                        if (&depth) raise_fault = 1'b1;
                        else        depth_n = depth + 1'b1;
                     end else if (RomData == INSN_LOOP_CLOSE && depth == DEPTH_ONE) begin
                        depth_n = '0;
                        mode_n  = M_NORMAL;
                     end else if (RomData == INSN_LOOP_CLOSE) begin
                        depth_n = depth - 1'b1;
                     end
                     if (mode_n == M_FWD && inc_wrap) raise_fault = 1'b1;
                  end
                  M_BWD: begin
                     if (RomData == INSN_LOOP_OPEN && depth == DEPTH_ONE) begin
                        depth_n = '0;
                        mode_n  = M_NORMAL;
                        insn_n  = RomData;
                        state_n = S_DONE;
                     end else begin
                        ip_n        = ip_dec;
                        rom_req_n   = 1'b1;
                        raise_fault = dec_wrap;
                        if (RomData == INSN_LOOP_CLOSE) begin
                           if (&depth) raise_fault = 1'b1;
                           else        depth_n = depth + 1'b1;
                        end else if (RomData == INSN_LOOP_OPEN) begin
                           depth_n = depth - 1'b1;
                        end
                     end
                  end
                  default: begin
                     insn_n  = RomData;
                     state_n = S_DONE;
                  end
               endcase
            end
         end
         S_DONE: begin
            if (!Request) state_n = S_IDLE;
         end
         default: begin
            if (!HaltRq && !fault) state_n = S_IDLE;
         end
      endcase
      if (raise_fault) begin
         fault_n   = 1'b1;
         state_n   = S_HALT;
         mode_n    = M_NORMAL;
         depth_n   = '0;
         ip_n      = ip;
         rom_req_n = 1'b0;
         push      = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= S_IDLE;
         mode    <= M_NORMAL;
         primed  <= 1'b0;
         ip      <= '0;
         insn    <= INSN_NOP;
         level   <= '0;
         miss    <= '0;
         depth   <= '0;
         ovf     <= 1'b0;
         fault   <= 1'b0;
         rom_req <= 1'b0;
      end else begin
         state   <= state_n;
         mode    <= mode_n;
         primed  <= primed_n;
         ip      <= ip_n;
         insn    <= insn_n;
         miss    <= miss_n;
         depth   <= depth_n;
         ovf     <= ovf_n;
         fault   <= fault_n;
         rom_req <= rom_req_n;
         if (push)     level <= level + 1'b1;
         else if (pop) level <= level - 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) stack[level] <= ip;
   end

   assign Ready         = ~Request & (state == S_IDLE);
   assign IpAddress     = ip;
   assign LoopDepth     = depth;
   assign StackLevel    = level;
   assign StackOverflow = ovf;
   assign Fault         = fault;
   assign RomRequest    = rom_req;
   assign Insn          = insn;

endmodule

// File: tb/tb_ip_line_stack.sv
// tb/tb_ip_line_stack.sv - self-checking bench for ip_line_stack with a fetch-level reference model
module tb_ip_line_stack;
   import dpc_pkg::*;

   localparam int IPD = 2;
   localparam int SD  = 2;
   localparam int MOD = 100;
   localparam int LW  = $clog2(SD + 1);

   logic                  Clk = 1'b0;
   logic                  Rst_n = 1'b0;
   logic                  HaltRq = 1'b0;
   logic                  DataIsZero = 1'b0;
   logic                  Request = 1'b0;
   logic                  RomReady = 1'b0;
   logic [INSN_WIDTH-1:0] RomData = '0;
   logic                  Ready;
   logic [IPD*4-1:0]      IpAddress;
   logic [7:0]            LoopDepth;
   logic [LW-1:0]         StackLevel;
   logic                  StackOverflow;
   logic                  Fault;
   logic                  RomRequest;
   logic [INSN_WIDTH-1:0] Insn;

   ip_line_stack #(
      .IP_DIGITS   (IPD),
      .STACK_DEPTH (SD),
      .SCAN_WIDTH  (8),
      .MISS_WIDTH  (8)
   ) dut (
      .Clk           (Clk),
      .Rst_n         (Rst_n),
      .HaltRq        (HaltRq),
      .DataIsZero    (DataIsZero),
      .Request       (Request),
      .Ready         (Ready),
      .IpAddress     (IpAddress),
      .LoopDepth     (LoopDepth),
      .StackLevel    (StackLevel),
      .StackOverflow (StackOverflow),
      .Fault         (Fault),
      .RomRequest    (RomRequest),
      .RomReady      (RomReady),
      .RomData       (RomData),
      .Insn          (Insn)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int addr;
      int depth;
   } fetch_t;

   int          checks = 0;
   int          errors = 0;
   logic [3:0]  rom [0:MOD-1];
   fetch_t      exp_q [$];
   int          m_ip, m_miss;
   logic [3:0]  m_insn;
   bit          m_primed, m_ovf, m_fault;
   int          m_stack [$];
   int          fetch_cnt = 0;
   int          max_depth = 0;
   bit          pend = 1'b0;
   int          pend_addr = 0;
   logic [7:0]  last_req = '0;

   function automatic int dec_ip(logic [7:0] a);
      return int'(a[7:4]) * 10 + int'(a[3:0]);
   endfunction

   task automatic check(string name, int act, int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic rom_clear();
      for (int i = 0; i < MOD; i++) rom[i] = INSN_NOP;
   endtask

   task automatic exp_fetch(int a, int d);
      exp_q.push_back('{addr: a, depth: d});
   endtask

   // Reference: what one executed instruction does, expressed as the list of fetches it causes.
   task automatic model_request(bit dz);
      int         d;
      logic [3:0] c;
      if (!m_primed) begin
         m_primed = 1'b1;
         exp_fetch(m_ip, 0);
         m_insn = rom[m_ip];
         return;
      end
      if (m_insn == INSN_LOOP_OPEN && !dz) begin
         if (m_stack.size() < SD) m_stack.push_back(m_ip);
         else begin m_miss++; m_ovf = 1'b1; end
         m_ip = (m_ip + 1) % MOD;
         exp_fetch(m_ip, 0);
         m_insn = rom[m_ip];
      end else if (m_insn == INSN_LOOP_OPEN) begin
         d = 1;
         while (1) begin
            if (m_ip == MOD - 1) begin m_fault = 1'b1; return; end
            m_ip++;
            exp_fetch(m_ip, d);
            c = rom[m_ip];
            if (c == INSN_LOOP_OPEN) d++;
            else if (c == INSN_LOOP_CLOSE) begin
               d--;
               if (d == 0) begin
                  m_ip = (m_ip + 1) % MOD;
                  exp_fetch(m_ip, 0);
                  m_insn = rom[m_ip];
                  return;
               end
            end
         end
      end else if (m_insn == INSN_LOOP_CLOSE && !dz) begin
         if (m_miss == 0 && m_stack.size() > 0) begin
            m_ip = m_stack.pop_back();
            exp_fetch(m_ip, 0);
            m_insn = rom[m_ip];
         end else begin
            if (m_miss > 0) m_miss--;
            d = 1;
            while (1) begin
               if (m_ip == 0) begin m_fault = 1'b1; return; end
               m_ip--;
               exp_fetch(m_ip, d);
               c = rom[m_ip];
               if (c == INSN_LOOP_CLOSE) d++;
               else if (c == INSN_LOOP_OPEN) begin
                  d--;
                  if (d == 0) begin m_insn = c; return; end
               end
            end
         end
      end else begin
         if (m_insn == INSN_LOOP_CLOSE) begin
            if (m_miss > 0) m_miss--;
            else if (m_stack.size() > 0) void'(m_stack.pop_back());
         end
         m_ip = (m_ip + 1) % MOD;
         exp_fetch(m_ip, 0);
         m_insn = rom[m_ip];
      end
   endtask

   task automatic check_state();
      if (!m_fault) check("ip", dec_ip(IpAddress), m_ip);
      check("insn", Insn, m_insn);
      check("stack_level", StackLevel, m_stack.size());
      check("overflow", StackOverflow, m_ovf);
      check("fault", Fault, m_fault);
      check("loop_depth", LoopDepth, 0);
      check("ready", Ready, !m_fault);
      check("fetches_left", exp_q.size(), 0);
   endtask

   task automatic do_request(bit dz);
      int n;
      DataIsZero = dz;
      model_request(dz);
      Request = 1'b1;
      @(negedge Clk);
      Request = 1'b0;
      n = 0;
      while (!Ready && !Fault && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("FAIL request_timeout: actual no Ready after %0d cycles, required Ready or Fault", n);
      end
      check_state();
   endtask

   task automatic do_reset(bit at_once);
      if (!at_once) @(negedge Clk);
      Rst_n   = 1'b0;
      Request = 1'b0;
      HaltRq  = 1'b0;
      #1;
      check("rst_ip", dec_ip(IpAddress), 0);
      check("rst_insn", Insn, INSN_NOP);
      check("rst_level", StackLevel, 0);
      check("rst_depth", LoopDepth, 0);
      check("rst_overflow", StackOverflow, 0);
      check("rst_fault", Fault, 0);
      check("rst_romreq", RomRequest, 0);
      check("rst_ready", Ready, 1);
      m_ip = 0; m_insn = INSN_NOP; m_primed = 1'b0; m_miss = 0;
      m_ovf = 1'b0; m_fault = 1'b0;
      m_stack.delete();
      exp_q.delete();
      @(negedge Clk);
      Rst_n = 1'b1;
      fetch_cnt = 0;
      max_depth = 0;
   endtask

   // One-cycle ROM: acknowledges the cycle after it sees a fetch pulse.
   initial forever begin
      @(posedge Clk);
      #1;
      RomReady = 1'b0;
      if (!Rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            RomReady = 1'b1;
            RomData  = rom[pend_addr];
            pend     = 1'b0;
         end
         if (RomRequest) begin
            pend      = 1'b1;
            pend_addr = dec_ip(IpAddress);
            last_req  = IpAddress;
         end
      end
   end

   initial forever begin
      fetch_t e;
      @(negedge Clk);
      if (Rst_n && RomRequest) begin
         fetch_cnt++;
         if (LoopDepth > max_depth) max_depth = LoopDepth;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: actual address %0d, required no fetch", dec_ip(IpAddress));
         end else begin
            e = exp_q.pop_front();
            check("fetch_addr", dec_ip(IpAddress), e.addr);
            check("fetch_depth", LoopDepth, e.depth);
         end
      end
      if (Rst_n && RomReady) check("addr_stable", IpAddress, last_req);
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL global_timeout: actual still running, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int n;
      rom_clear();
      repeat (2) @(negedge Clk);

      // First request after reset: single fetch at 0, Ready held off until Request drops.
      rom[0] = INSN_LOOP_OPEN;
      rom[2] = INSN_LOOP_CLOSE;
      do_reset(1'b0);
      DataIsZero = 1'b0;
      model_request(1'b0);
      Request = 1'b1;
      repeat (20) @(negedge Clk);
      check("ready_held", Ready, 0);
      check("prime_insn", Insn, INSN_LOOP_OPEN);
      check("prime_fetches", fetch_cnt, 1);
      check("prime_ip", dec_ip(IpAddress), 0);
      Request = 1'b0;
      @(negedge Clk);
      check("ready_return", Ready, 1);
      check_state();

      // Stack jump on ']' with data != 0, then a ']' with data = 0 falls through.
      do_request(1'b0);
      check("push_level", StackLevel, 1);
      do_request(1'b0);
      fetch_cnt = 0;
      do_request(1'b0);
      check("jump_ip", dec_ip(IpAddress), 0);
      check("jump_fetches", fetch_cnt, 1);
      check("jump_level", StackLevel, 0);
      check("jump_insn", Insn, INSN_LOOP_OPEN);
      do_request(1'b0);
      do_request(1'b0);
      do_request(1'b1);
      check("fall_ip", dec_ip(IpAddress), 3);
      check("fall_level", StackLevel, 0);

      // Forward skip over a nested pair.
      rom_clear();
      rom[0] = INSN_LOOP_OPEN;  rom[1] = INSN_LOOP_OPEN;
      rom[2] = INSN_LOOP_CLOSE; rom[3] = INSN_LOOP_CLOSE;
      do_reset(1'b0);
      do_request(1'b1);
      fetch_cnt = 0;
      max_depth = 0;
      do_request(1'b1);
      check("fwd_fetches", fetch_cnt, 4);
      check("fwd_peak_depth", max_depth, 2);
      check("fwd_ip", dec_ip(IpAddress), 4);
      check("fwd_insn", Insn, INSN_NOP);

      // Stack overflow, then the unstacked ']' scans back to the innermost '['.
      rom_clear();
      rom[0] = INSN_LOOP_OPEN; rom[1] = INSN_LOOP_OPEN; rom[2] = INSN_LOOP_OPEN;
      rom[3] = INSN_LOOP_CLOSE;
      do_reset(1'b0);
      do_request(1'b0);
      for (int i = 0; i < 3; i++) do_request(1'b0);
      check("ovf_level", StackLevel, 2);
      check("ovf_flag", StackOverflow, 1);
      check("ovf_ip", dec_ip(IpAddress), 3);
      do_request(1'b0);
      check("bwd_ip", dec_ip(IpAddress), 2);
      check("bwd_insn", Insn, INSN_LOOP_OPEN);
      check("bwd_level", StackLevel, 2);

      // Unmatched '[' at 5: forward scan wraps at 99 and faults.
      rom_clear();
      rom[5] = INSN_LOOP_OPEN;
      do_reset(1'b0);
      do_request(1'b0);
      for (int i = 0; i < 5; i++) do_request(1'b0);
      do_request(1'b1);
      check("wrap_fault", Fault, 1);
      repeat (5) @(negedge Clk);
      check("halt_ready", Ready, 0);
      check("halt_fault", Fault, 1);

      // Halt request in IDLE, release, normal fetch afterwards.
      rom_clear();
      rom[0] = INSN_LOOP_CLOSE;
      do_reset(1'b0);
      check("fault_cleared", Fault, 0);
      HaltRq = 1'b1;
      repeat (2) @(negedge Clk);
      check("haltrq_ready", Ready, 0);
      HaltRq = 1'b0;
      n = 0;
      while (!Ready && n < 20) begin @(negedge Clk); n++; end
      check("halt_release", Ready, 1);
      fetch_cnt = 0;
      do_request(1'b0);
      check("after_halt_ip", dec_ip(IpAddress), 0);
      check("after_halt_insn", Insn, INSN_LOOP_CLOSE);
      check("after_halt_fetches", fetch_cnt, 1);

      // Reset with a scan fetch outstanding.
      rom_clear();
      rom[0] = INSN_LOOP_OPEN;
      do_reset(1'b0);
      do_request(1'b0);
      fetch_cnt = 0;
      DataIsZero = 1'b1;
      model_request(1'b1);
      Request = 1'b1;
      @(negedge Clk);
      Request = 1'b0;
      n = 0;
      while (!(RomRequest && fetch_cnt >= 9) && n < 200) begin @(negedge Clk); n++; end
      check("scan_running", (n < 200) ? 1 : 0, 1);
      check("scan_depth", LoopDepth, 1);
      do_reset(1'b1);
      fetch_cnt = 0;
      do_request(1'b0);
      check("post_rst_ip", dec_ip(IpAddress), 0);
      check("post_rst_fetches", fetch_cnt, 1);
      check("post_rst_insn", Insn, INSN_LOOP_OPEN);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
